// File: rtl/client_tx_msg_pkg.sv
// Shared state encoding, pad byte and default derived widths for the transmit client.
package client_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_SEND = 2'd2
    } state_t;

    localparam logic [7:0] PAD_BYTE = 8'h00;

    localparam int DEF_N_MSG  = 4;
    localparam int DEF_MSG_AW = 6;
    localparam int sel_w      = $clog2(DEF_N_MSG);
    localparam int buf_aw     = sel_w + DEF_MSG_AW;

    function automatic int calc_sel_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/client_tx_msg_if.sv
// Client-to-core transmit handshake. The client holds req and length until it samples ack
// high; the core then raises strobe once per payload byte, and data_out is valid in that cycle.
interface client_tx_msg_if
    import client_tx_pkg::*;
#(
    parameter int jumbo_dw = 14
);
    logic                req;
    logic                ack;
    logic                strobe;
    logic [jumbo_dw-1:0] length;
    logic [7:0]          data_out;

    modport master (output req, length, data_out, input ack, strobe);
    modport slave  (input req, length, data_out, output ack, strobe);
endinterface

// File: rtl/client_tx_msg_ram.sv
// Simple dual-port byte RAM: independent write port, registered read port.
module client_tx_msg_ram #(
    parameter int aw = 8
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [aw-1:0] i_waddr,
    input  logic [7:0]    i_wdata,
    input  logic [aw-1:0] i_raddr,
    output logic [7:0]    o_rdata
);
    logic [7:0] r_mem [2**aw];
    logic [7:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;
endmodule

// File: rtl/client_tx_msg.sv
// Transmit-only Ethernet client: n_msg host-writable buffers sent on srx or a periodic tick,
// with a one-deep pending slot, drop accounting and packet counters.
module client_tx_msg
    import client_tx_pkg::*;
#(
    parameter  int jumbo_dw = 14,
    parameter  int n_msg    = DEF_N_MSG,
    parameter  int msg_aw   = DEF_MSG_AW,
    parameter  int period_w = 18,
    localparam int SEL_W    = calc_sel_w(n_msg),
    localparam int BUF_AW   = SEL_W + msg_aw,
    localparam int LEN_W    = msg_aw + 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               srx,
    input  logic [SEL_W-1:0]   trig_sel,
    input  logic               periodic_en,
    input  logic [SEL_W-1:0]   periodic_sel,
    input  logic               cfg_we,
    input  logic [BUF_AW-1:0]  cfg_addr,
    input  logic [7:0]         cfg_data,
    input  logic               len_we,
    input  logic [SEL_W-1:0]   len_sel,
    input  logic [LEN_W-1:0]   len_data,
    client_tx_msg_if.master    tx,
    output logic               busy,
    output logic [15:0]        tx_count,
    output logic [15:0]        drop_count,
    output state_t             o_dbg_state
);
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(2**msg_aw);

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_req;
    logic [jumbo_dw-1:0] r_length;
    logic [SEL_W-1:0]    r_sel;
    logic [LEN_W-1:0]    r_idx;
    logic [LEN_W-1:0]    w_idx_nxt;
    logic                r_strobe_d;
    logic [period_w-1:0] r_timer;
    logic                r_pend_vld;
    logic [SEL_W-1:0]    r_pend_sel;
    logic [15:0]         r_tx_count;
    logic [15:0]         r_drop_count;
    logic [LEN_W-1:0]    r_len [n_msg];

    logic                w_tick_trig;
    logic [2:0]          w_cand_vld;
    logic [SEL_W-1:0]    w_cand_sel [3];
    logic                w_head_taken;
    logic                w_accept;
    logic [SEL_W-1:0]    w_acc_sel;
    logic                w_pend_vld_nxt;
    logic [SEL_W-1:0]    w_pend_sel_nxt;
    logic [1:0]          w_drop_inc;
    logic                w_pkt_done;
    logic [7:0]          w_rdata;

    assign w_tick_trig   = (r_timer == '1) && periodic_en;
    // Priority order for this cycle: older pending entry, then srx, then the timer tick.
    assign w_cand_vld    = {w_tick_trig, srx, r_pend_vld};
    assign w_cand_sel[0] = r_pend_sel;
    assign w_cand_sel[1] = trig_sel;
    assign w_cand_sel[2] = periodic_sel;

    always_comb begin
        w_head_taken   = 1'b0;
        w_accept       = 1'b0;
        w_acc_sel      = '0;
        w_pend_vld_nxt = r_pend_vld;
        w_pend_sel_nxt = r_pend_sel;
        w_drop_inc     = 2'd0;
        if (r_state == ST_IDLE) begin
            w_pend_vld_nxt = 1'b0;
        end
        for (int i = 0; i < 3; i++) begin
            if (w_cand_vld[i] && ((r_state == ST_IDLE) || (i != 0))) begin
                if ((r_state == ST_IDLE) && !w_head_taken) begin
                    w_head_taken = 1'b1;
                    if (r_len[w_cand_sel[i]] == '0) begin
                        w_drop_inc = w_drop_inc + 2'd1;
                    end else begin
                        w_accept  = 1'b1;
                        w_acc_sel = w_cand_sel[i];
                    end
                end else if (!w_pend_vld_nxt) begin
                    w_pend_vld_nxt = 1'b1;
                    w_pend_sel_nxt = w_cand_sel[i];
                end else begin
                    w_drop_inc = w_drop_inc + 2'd1;
                end
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pkt_done  = 1'b0;
        unique case (r_state)
            ST_IDLE: if (w_accept) w_state_nxt = ST_REQ;
            ST_REQ:  if (tx.ack) w_state_nxt = ST_SEND;
            ST_SEND: begin
                if (r_strobe_d && !tx.strobe) begin
                    w_pkt_done  = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // The RAM is addressed with the index of the next strobe cycle so its registered
    // output lines up with the cycle in which that byte is presented.
    always_comb begin
        w_idx_nxt = '0;
        if ((r_state == ST_SEND) && tx.strobe) begin
            w_idx_nxt = (r_idx == '1) ? r_idx : r_idx + LEN_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_req        <= 1'b0;
            r_length     <= '0;
            r_sel        <= '0;
            r_idx        <= '0;
            r_strobe_d   <= 1'b0;
            r_timer      <= '0;
            r_pend_vld   <= 1'b0;
            r_pend_sel   <= '0;
            r_tx_count   <= '0;
            r_drop_count <= '0;
            for (int i = 0; i < n_msg; i++) begin
                r_len[i] <= '0;
            end
        end else begin
            r_state      <= w_state_nxt;
            r_timer      <= r_timer + period_w'(1);
            r_strobe_d   <= tx.strobe;
            r_idx        <= w_idx_nxt;
            r_pend_vld   <= w_pend_vld_nxt;
            r_pend_sel   <= w_pend_sel_nxt;
            r_drop_count <= r_drop_count + 16'(w_drop_inc);
            if (w_accept) begin
                r_sel    <= w_acc_sel;
                r_length <= jumbo_dw'(r_len[w_acc_sel]);
                r_req    <= 1'b1;
            end else if ((r_state == ST_REQ) && tx.ack) begin
                r_req <= 1'b0;
            end
            if (w_pkt_done) begin
                r_tx_count <= r_tx_count + 16'd1;
                r_length   <= '0;
            end
            if (len_we) begin
                r_len[len_sel] <= (len_data > MAX_LEN) ? MAX_LEN : len_data;
            end
        end
    end

    client_tx_msg_ram #(
        .aw(BUF_AW)
    ) u_ram (
        .clk     (clk),
        .i_we    (cfg_we),
        .i_waddr (cfg_addr),
        .i_wdata (cfg_data),
        .i_raddr ({r_sel, w_idx_nxt[msg_aw-1:0]}),
        .o_rdata (w_rdata)
    );

    assign tx.req      = r_req;
    assign tx.length   = r_length;
    assign tx.data_out = ((r_state == ST_SEND) && tx.strobe && (jumbo_dw'(r_idx) < r_length))
                         ? w_rdata : PAD_BYTE;
    assign busy        = (r_state != ST_IDLE);
    assign tx_count    = r_tx_count;
    assign drop_count  = r_drop_count;
    assign o_dbg_state = r_state;
endmodule

// File: tb/tb_client_tx_msg.sv
// Directed bench for client_tx_msg: a small core model drives ack/strobe and records bytes.
module tb_client_tx_msg;
    import client_tx_pkg::*;

    localparam int JDW = 14;
    localparam int NM  = 4;
    localparam int MAW = 6;
    localparam int PW  = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        srx = 1'b0;
    logic [1:0]  trig_sel = '0;
    logic        periodic_en = 1'b0;
    logic [1:0]  periodic_sel = '0;
    logic        cfg_we = 1'b0;
    logic [7:0]  cfg_addr = '0;
    logic [7:0]  cfg_data = '0;
    logic        len_we = 1'b0;
    logic [1:0]  len_sel = '0;
    logic [6:0]  len_data = '0;
    logic        busy;
    logic [15:0] tx_count;
    logic [15:0] drop_count;
    state_t      dbg_state;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [7:0]  obs [80];
    logic [13:0] obs_len;
    logic [7:0]  hello [13] = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h20, 8'h57,
                                8'h6F, 8'h72, 8'h6C, 8'h64, 8'h21, 8'h0A};

    client_tx_msg_if #(.jumbo_dw(JDW)) tx ();

    client_tx_msg #(
        .jumbo_dw(JDW), .n_msg(NM), .msg_aw(MAW), .period_w(PW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .srx          (srx),
        .trig_sel     (trig_sel),
        .periodic_en  (periodic_en),
        .periodic_sel (periodic_sel),
        .cfg_we       (cfg_we),
        .cfg_addr     (cfg_addr),
        .cfg_data     (cfg_data),
        .len_we       (len_we),
        .len_sel      (len_sel),
        .len_data     (len_data),
        .tx           (tx),
        .busy         (busy),
        .tx_count     (tx_count),
        .drop_count   (drop_count),
        .o_dbg_state  (dbg_state)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_byte(input logic [1:0] b, input logic [5:0] i, input logic [7:0] d);
        cfg_we   = 1'b1;
        cfg_addr = {b, i};
        cfg_data = d;
        step();
        cfg_we   = 1'b0;
    endtask

    task automatic write_len(input logic [1:0] s, input logic [6:0] l);
        len_we   = 1'b1;
        len_sel  = s;
        len_data = l;
        step();
        len_we   = 1'b0;
    endtask

    task automatic pulse_srx(input logic [1:0] s);
        srx      = 1'b1;
        trig_sel = s;
        step();
        srx      = 1'b0;
    endtask

    task automatic core_ack(output logic got, output int rise_cyc);
        got      = 1'b0;
        rise_cyc = 0;
        for (int k = 0; k < 64; k++) begin
            if (tx.req === 1'b1) begin
                got      = 1'b1;
                rise_cyc = cyc;
                break;
            end
            step();
        end
        if (got) begin
            tx.ack = 1'b1;
            step();
            tx.ack = 1'b0;
        end
    endtask

    task automatic core_strobe(input int n);
        for (int k = 0; k < n; k++) begin
            tx.strobe = 1'b1;
            #1;
            obs[k] = tx.data_out;
            if (k == 0) obs_len = tx.length;
            @(posedge clk);
            #1;
        end
        tx.strobe = 1'b0;
        step();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (tx.req !== 1'b0 || tx.length !== 14'd0 || busy !== 1'b0 || tx.data_out !== 8'h00) begin
            errors++;
            $display("FAIL reset_outputs: req=%0b length=%0d busy=%0b data=%0h expected all 0",
                     tx.req, tx.length, busy, tx.data_out);
        end
        checks++;
        if (tx_count !== 16'd0 || drop_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_counts: tx=%0d drop=%0d expected 0 0", tx_count, drop_count);
        end
        rst_n = 1'b1;
        step();
        checks++;
        if (dbg_state !== ST_IDLE || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: state=%0d busy=%0b expected 0 0", dbg_state, busy);
        end
    endtask

    task automatic test_basic();
        logic got;
        int   rc;
        for (int i = 0; i < 13; i++) write_byte(2'd0, 6'(i), hello[i]);
        write_len(2'd0, 7'd13);
        pulse_srx(2'd0);
        checks++;
        if (tx.req !== 1'b1 || tx.length !== 14'd13 || busy !== 1'b1) begin
            errors++;
            $display("FAIL basic_req: req=%0b length=%0d busy=%0b expected 1 13 1", tx.req, tx.length, busy);
        end
        core_ack(got, rc);
        checks++;
        if (got !== 1'b1 || tx.req !== 1'b0) begin
            errors++;
            $display("FAIL basic_ack: got=%0b req=%0b expected 1 0", got, tx.req);
        end
        core_strobe(13);
        checks++;
        if (obs_len !== 14'd13) begin
            errors++;
            $display("FAIL basic_len_send: got %0d expected 13", obs_len);
        end
        for (int i = 0; i < 13; i++) begin
            checks++;
            if (obs[i] !== hello[i]) begin
                errors++;
                $display("FAIL basic_byte%0d: got %0h expected %0h", i, obs[i], hello[i]);
            end
        end
        checks++;
        if (tx_count !== 16'd1 || tx.length !== 14'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_done: tx=%0d length=%0d busy=%0b expected 1 0 0", tx_count, tx.length, busy);
        end
    endtask

    task automatic test_pending();
        logic got;
        int   rc;
        write_byte(2'd1, 6'd0, 8'h11);
        write_byte(2'd1, 6'd1, 8'h22);
        write_byte(2'd1, 6'd2, 8'h33);
        write_len(2'd1, 7'd3);
        write_byte(2'd2, 6'd0, 8'h5A);
        write_len(2'd2, 7'd2);
        pulse_srx(2'd0);
        pulse_srx(2'd1);
        checks++;
        if (tx.req !== 1'b1 || tx.length !== 14'd13) begin
            errors++;
            $display("FAIL pend_req_hold: req=%0b length=%0d expected 1 13", tx.req, tx.length);
        end
        core_ack(got, rc);
        pulse_srx(2'd2);
        checks++;
        if (drop_count !== 16'd1) begin
            errors++;
            $display("FAIL pend_drop: got %0d expected 1", drop_count);
        end
        core_strobe(13);
        checks++;
        if (obs_len !== 14'd13 || obs[12] !== 8'h0A) begin
            errors++;
            $display("FAIL pend_first_pkt: len=%0d last=%0h expected 13 0a", obs_len, obs[12]);
        end
        checks++;
        if (tx.req !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL pend_gap: req=%0b busy=%0b expected 0 0", tx.req, busy);
        end
        step();
        checks++;
        if (tx.req !== 1'b1 || tx.length !== 14'd3) begin
            errors++;
            $display("FAIL pend_second_req: req=%0b length=%0d expected 1 3", tx.req, tx.length);
        end
        core_ack(got, rc);
        core_strobe(3);
        checks++;
        if (obs[0] !== 8'h11 || obs[1] !== 8'h22 || obs[2] !== 8'h33) begin
            errors++;
            $display("FAIL pend_buf1_bytes: got %0h %0h %0h expected 11 22 33", obs[0], obs[1], obs[2]);
        end
        step();
        checks++;
        if (tx_count !== 16'd3 || drop_count !== 16'd1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL pend_counts: tx=%0d drop=%0d busy=%0b expected 3 1 0", tx_count, drop_count, busy);
        end
    endtask

    task automatic test_periodic();
        logic got;
        int   c1;
        int   c2;
        int   rc;
        for (int i = 0; i < 5; i++) write_byte(2'd3, 6'(i), 8'hA0 + 8'(i));
        write_len(2'd3, 7'd5);
        periodic_sel = 2'd3;
        periodic_en  = 1'b1;
        core_ack(got, c1);
        core_strobe(5);
        checks++;
        if (got !== 1'b1 || obs_len !== 14'd5 || obs[0] !== 8'hA0 || obs[4] !== 8'hA4) begin
            errors++;
            $display("FAIL per_first: got=%0b len=%0d b0=%0h b4=%0h expected 1 5 a0 a4", got, obs_len, obs[0], obs[4]);
        end
        core_ack(got, c2);
        core_strobe(5);
        checks++;
        if (got !== 1'b1 || (c2 - c1) !== 16 || obs_len !== 14'd5) begin
            errors++;
            $display("FAIL per_interval: got=%0b interval=%0d len=%0d expected 1 16 5", got, c2 - c1, obs_len);
        end
        while (cyc < c2 + 15) step();
        srx      = 1'b1;
        trig_sel = 2'd0;
        step();
        srx         = 1'b0;
        periodic_en = 1'b0;
        checks++;
        if (tx.req !== 1'b1 || tx.length !== 14'd13) begin
            errors++;
            $display("FAIL per_collide_first: req=%0b length=%0d expected 1 13", tx.req, tx.length);
        end
        core_ack(got, rc);
        core_strobe(13);
        core_ack(got, rc);
        core_strobe(5);
        checks++;
        if (got !== 1'b1 || obs_len !== 14'd5 || obs[1] !== 8'hA1) begin
            errors++;
            $display("FAIL per_collide_second: got=%0b len=%0d b1=%0h expected 1 5 a1", got, obs_len, obs[1]);
        end
        checks++;
        if (tx_count !== 16'd7 || drop_count !== 16'd1) begin
            errors++;
            $display("FAIL per_counts: tx=%0d drop=%0d expected 7 1", tx_count, drop_count);
        end
    endtask

    task automatic test_zero_len_sat();
        logic got;
        int   rc;
        write_len(2'd1, 7'd0);
        pulse_srx(2'd1);
        checks++;
        if (tx.req !== 1'b0 || busy !== 1'b0 || drop_count !== 16'd2) begin
            errors++;
            $display("FAIL zero_len: req=%0b busy=%0b drop=%0d expected 0 0 2", tx.req, busy, drop_count);
        end
        step();
        checks++;
        if (tx.req !== 1'b0) begin
            errors++;
            $display("FAIL zero_len_later: req=%0b expected 0", tx.req);
        end
        write_len(2'd1, 7'd100);
        pulse_srx(2'd1);
        checks++;
        if (tx.req !== 1'b1 || tx.length !== 14'd64) begin
            errors++;
            $display("FAIL sat_len: req=%0b length=%0d expected 1 64", tx.req, tx.length);
        end
        core_ack(got, rc);
        core_strobe(64);
        checks++;
        if (obs[0] !== 8'h11 || obs[2] !== 8'h33 || tx_count !== 16'd8) begin
            errors++;
            $display("FAIL sat_pkt: b0=%0h b2=%0h tx=%0d expected 11 33 8", obs[0], obs[2], tx_count);
        end
    endtask

    task automatic test_pad();
        logic       got;
        int         rc;
        logic [7:0] exp_b;
        for (int i = 0; i < 20; i++) write_byte(2'd2, 6'(i), (i < 16) ? 8'h80 + 8'(i) : 8'hFF);
        write_len(2'd2, 7'd16);
        pulse_srx(2'd2);
        core_ack(got, rc);
        core_strobe(20);
        for (int i = 0; i < 20; i++) begin
            exp_b = (i < 16) ? 8'h80 + 8'(i) : 8'h00;
            checks++;
            if (obs[i] !== exp_b) begin
                errors++;
                $display("FAIL pad_byte%0d: got %0h expected %0h", i, obs[i], exp_b);
            end
        end
        checks++;
        if (tx_count !== 16'd9 || tx.length !== 14'd0) begin
            errors++;
            $display("FAIL pad_done: tx=%0d length=%0d expected 9 0", tx_count, tx.length);
        end
    endtask

    task automatic test_mid_reset();
        logic got;
        int   rc;
        pulse_srx(2'd0);
        core_ack(got, rc);
        for (int k = 0; k < 5; k++) begin
            tx.strobe = 1'b1;
            step();
        end
        #1;
        checks++;
        if (tx.data_out !== 8'h20) begin
            errors++;
            $display("FAIL rst_byte5: got %0h expected 20", tx.data_out);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (tx.req !== 1'b0 || tx.length !== 14'd0 || busy !== 1'b0 || tx.data_out !== 8'h00) begin
            errors++;
            $display("FAIL rst_outputs: req=%0b length=%0d busy=%0b data=%0h expected all 0",
                     tx.req, tx.length, busy, tx.data_out);
        end
        checks++;
        if (tx_count !== 16'd0 || drop_count !== 16'd0) begin
            errors++;
            $display("FAIL rst_counts: tx=%0d drop=%0d expected 0 0", tx_count, drop_count);
        end
        tx.strobe = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        pulse_srx(2'd0);
        checks++;
        if (tx.req !== 1'b0 || drop_count !== 16'd1) begin
            errors++;
            $display("FAIL rst_len_cleared: req=%0b drop=%0d expected 0 1", tx.req, drop_count);
        end
        write_len(2'd0, 7'd13);
        pulse_srx(2'd0);
        checks++;
        if (tx.req !== 1'b1 || tx.length !== 14'd13) begin
            errors++;
            $display("FAIL rst_clean_req: req=%0b length=%0d expected 1 13", tx.req, tx.length);
        end
        core_ack(got, rc);
        core_strobe(13);
        for (int i = 0; i < 13; i++) begin
            checks++;
            if (obs[i] !== hello[i]) begin
                errors++;
                $display("FAIL rst_byte%0d: got %0h expected %0h", i, obs[i], hello[i]);
            end
        end
        checks++;
        if (tx_count !== 16'd1 || drop_count !== 16'd1) begin
            errors++;
            $display("FAIL rst_final_counts: tx=%0d drop=%0d expected 1 1", tx_count, drop_count);
        end
    endtask

    initial begin
        tx.ack    = 1'b0;
        tx.strobe = 1'b0;
        test_reset();
        test_basic();
        test_pending();
        test_periodic();
        test_zero_len_sat();
        test_pad();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "watchdog");
    end
endmodule
